// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux stream multiplexer.
package arb_mux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  // Width of a channel index for n channels (at least one bit).
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating priority encoder: grants the first requesting channel at or
// above ptr, wrapping from NCH-1 back to 0.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [NCH-1:0] rot;
  logic [SELW:0]  sum;

  // Rotate requests so bit 0 is the channel at ptr, then take the lowest set bit.
  always_comb begin
    rot     = NCH'({req, req} >> ptr);
    sum     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr} + (SELW + 1)'(j);
        if (sum >= (SELW + 1)'(NCH)) sum = sum - (SELW + 1)'(NCH);
        gnt_idx = sum[SELW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered NCH-channel stream multiplexer with valid/ready handshake.
// Channel chosen by address, or by round-robin when ARB_MUX_RR_EN is defined.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      address,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic             load;
  logic             addr_vld;
  logic [SELW-1:0]  gnt_p0;
  logic             gnt_vld_p0;
  logic [WIDTH-1:0] word_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  chan_p1;

  assign load = !vld_p1 | out_ready;

  // Address grant; an out-of-range address matches no channel.
  always_comb begin
    addr_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (address == SELW'(k)) addr_vld = in_valid[k];
    end
  end

`ifdef ARB_MUX_RR_EN
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_vld;

  rr_pick #(.NCH(NCH)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign gnt_p0     = (mode == MODE_RR) ? rr_idx : address;
  assign gnt_vld_p0 = (mode == MODE_RR) ? rr_vld : addr_vld;

  // Round-robin pointer moves past the winner only on round-robin transfers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (load && gnt_vld_p0 && mode == MODE_RR) begin
      ptr <= (gnt_p0 == SELW'(NCH - 1)) ? '0 : gnt_p0 + 1'b1;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign gnt_p0      = address;
  assign gnt_vld_p0  = addr_vld;
`endif

  // Word of the granted channel.
  always_comb begin
    word_p0 = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_p0 == SELW'(k)) word_p0 = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Accept strobe to the granted channel only; forced low during reset.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      in_ready[k] = reset_n & load & gnt_vld_p0 & (gnt_p0 == SELW'(k));
    end
  end

  // ---- stage p0 -> p1: output register ----
  // Load on enable; an empty grant drops valid but keeps the last word and channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
    end else if (load) begin
      vld_p1 <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        data_p1 <= word_p0;
        chan_p1 <= gnt_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_chan  = chan_p1;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: reference model plus directed vectors.
module tb_arb_mux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
`ifdef ARB_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 mode;
  logic [1:0]           address;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_chan;
  logic                 out_ready;

  int n_vec = 0;
  int n_bad = 0;

  arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .address   (address),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: channel index granted under the current rules, or -1.
  function automatic int model_grant(input logic [NCH-1:0] v, input logic md,
                                     input int a, input int p);
    if (RR && md) begin
      for (int i = 0; i < NCH; i++)
        if (v[(p + i) % NCH]) return (p + i) % NCH;
      return -1;
    end
    if (a < NCH && v[a]) return a;
    return -1;
  endfunction

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_chan;
  int               m_ptr;
  int               g;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= 0;
      m_ptr   <= 0;
    end else begin
      g = model_grant(in_valid, mode, int'(address), m_ptr);
      if (!m_valid || out_ready) begin
        if (g >= 0) begin
          m_valid <= 1'b1;
          m_data  <= in_data[g*WIDTH +: WIDTH];
          m_chan  <= g;
          if (RR && mode) m_ptr <= (g + 1) % NCH;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    int eg;
    logic [NCH-1:0] exp_rdy;
    eg = model_grant(in_valid, mode, int'(address), m_ptr);
    exp_rdy = '0;
    if (reset_n && (!m_valid || out_ready) && eg >= 0) exp_rdy[eg] = 1'b1;
    chk("model.in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("model.out_valid", 32'(out_valid), 32'(m_valid));
    chk("model.out_data", 32'(out_data), 32'(m_data));
    chk("model.out_chan", 32'(out_chan), 32'(m_chan));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep [4];
  int         rr_seq [6];

  initial begin
    sweep  = '{8'h10, 8'h21, 8'h32, 8'h43};
    rr_seq = '{0, 1, 3, 0, 1, 3};

    // Reset with all channels requesting.
    reset_n   = 1'b0;
    out_ready = 1'b1;
    mode      = 1'b0;
    address   = 2'd2;
    in_valid  = 4'hF;
    in_data   = {8'h43, 8'hA5, 8'h21, 8'h10};
    repeat (2) tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_chan", 32'(out_chan), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    #1 reset_n = 1'b1;
    tick();
    chk("first.out_valid", 32'(out_valid), 32'd1);
    chk("first.out_data", 32'(out_data), 32'hA5);
    chk("first.out_chan", 32'(out_chan), 32'd2);

    // Address sweep at full throughput.
    in_data[23:16] = 8'h32;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1 chk("sweep.in_ready", 32'(in_ready), 32'(1 << a));
      tick();
      chk("sweep.out_data", 32'(out_data), 32'(sweep[a]));
      chk("sweep.out_chan", 32'(out_chan), 32'(a));
    end

    // Back-pressure.
    address = 2'd1;
    tick();
    chk("bp.load", 32'(out_data), 32'h21);
    out_ready = 1'b0;
    address   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.out_data", 32'(out_data), 32'h21);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_rdy", 32'(in_ready), 32'h8);
    tick();
    chk("bp.next_data", 32'(out_data), 32'h43);
    chk("bp.next_chan", 32'(out_chan), 32'd3);

    // Empty / invalid channel.
    address  = 2'd1;
    in_valid = 4'b1101;
    #1 chk("empty.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("empty.out_valid", 32'(out_valid), 32'd0);
    chk("empty.hold_data", 32'(out_data), 32'h43);
    chk("empty.in_ready2", 32'(in_ready), 32'd0);
    in_valid = 4'hF;
    tick();
    chk("refill.out_valid", 32'(out_valid), 32'd1);
    chk("refill.out_data", 32'(out_data), 32'h21);
    chk("refill.out_chan", 32'(out_chan), 32'd1);

`ifdef ARB_MUX_RR_EN
    // Round-robin skipping channel 2.
    mode     = 1'b1;
    in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr.out_chan", 32'(out_chan), 32'(rr_seq[i]));
    end
    // Leave the pointer at 1 before the mid-operation reset.
    tick();
    chk("rr.pre_chan", 32'(out_chan), 32'd0);
`endif

    // Reset while full and stalled.
    mode     = 1'b0;
    address  = 2'd2;
    in_valid = 4'hF;
    tick();
    chk("mid.load", 32'(out_data), 32'h32);
    out_ready = 1'b0;
    tick();
    chk("mid.stall", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("mid.async_valid", 32'(out_valid), 32'd0);
    chk("mid.async_data", 32'(out_data), 32'd0);
    chk("mid.async_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
`ifdef ARB_MUX_RR_EN
    mode     = 1'b1;
    in_valid = 4'b1011;
`else
    address = 2'd3;
`endif
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    chk("post.out_valid", 32'(out_valid), 32'd1);
`ifdef ARB_MUX_RR_EN
    chk("post.out_chan", 32'(out_chan), 32'd0);
    chk("post.out_data", 32'(out_data), 32'h10);
`else
    chk("post.out_chan", 32'(out_chan), 32'd3);
    chk("post.out_data", 32'(out_data), 32'h43);
`endif
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
